// File: rtl/pool_pkg.sv
// Shared types and default geometry for the 2x2 max-pooling path
// (window generator and pooling stage).
package pool_pkg;

  localparam int POOL_DATA_W = 8;
  localparam int POOL_IMG_W  = 8;
  localparam int POOL_IMG_H  = 8;

  typedef logic signed [POOL_DATA_W-1:0] pixel_t;

  // a=top-left, b=top-right, c=bottom-left, d=bottom-right
  typedef struct packed {
    pixel_t a;
    pixel_t b;
    pixel_t c;
    pixel_t d;
  } pool_win_t;

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel stream in / 2x2 window out bundle for pool_window_gen.
interface pool_window_gen_if import pool_pkg::*; #(
  parameter int DATA_W = POOL_DATA_W
);

  // Handshake: pix_valid qualifies pix_in and pix_sof; there is no ready,
  // so the generator takes every valid pixel. win_en qualifies win_a..win_d
  // for exactly one cycle and the sink has no way to stall it.
  logic signed [DATA_W-1:0] pix_in;
  logic                     pix_valid;
  logic                     pix_sof;
  logic signed [DATA_W-1:0] win_a;
  logic signed [DATA_W-1:0] win_b;
  logic signed [DATA_W-1:0] win_c;
  logic signed [DATA_W-1:0] win_d;
  logic                     win_en;
  logic                     frame_done;
  logic                     sync_err;

  modport master (
    output pix_in, pix_valid, pix_sof,
    input  win_a, win_b, win_c, win_d, win_en, frame_done, sync_err
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof,
    output win_a, win_b, win_c, win_d, win_en, frame_done, sync_err
  );

endinterface

// File: rtl/pool_line_buf.sv
// Single-row pixel buffer: synchronous write, combinational read, one shared
// column address.
module pool_line_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows for the
// max-pooling stage, buffering the even row of each row pair.
module pool_window_gen import pool_pkg::*; #(
  parameter int DATA_W = POOL_DATA_W,
  parameter int IMG_W  = POOL_IMG_W,
  parameter int IMG_H  = POOL_IMG_H
) (
  input logic               clk,
  input logic               rst,
  pool_window_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, eff_col, col_nxt;
  logic [RW-1:0] row, eff_row, row_nxt;
  logic          sof_take, at_origin, odd_row, odd_col, buf_we;

  logic [DATA_W-1:0]        buf_rd;
  logic signed [DATA_W-1:0] hold, top_hold;
  logic signed [DATA_W-1:0] win_a, win_b, win_c, win_d;
  logic                     win_en, frame_done, sync_err;

  // A start-of-frame pixel is always placed at (0,0), whatever the counters say.
  always_comb begin
    sof_take  = bus.pix_valid && bus.pix_sof;
    at_origin = (col == '0) && (row == '0);
    eff_col   = sof_take ? '0 : col;
    eff_row   = sof_take ? '0 : row;
    odd_row   = eff_row[0];
    odd_col   = eff_col[0];
    buf_we    = bus.pix_valid && !odd_row;
    col_nxt   = (eff_col == COL_LAST) ? '0 : eff_col + CW'(1);
    row_nxt   = eff_row;
    if (eff_col == COL_LAST) begin
      row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
    end
  end

  pool_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (eff_col),
    .wdata (bus.pix_in),
    .rdata (buf_rd)
  );

  // On the even column of an odd row, capture both left-hand pixels so the
  // odd column needs only one line-buffer read.
  always_ff @(posedge clk) begin
    if (bus.pix_valid && odd_row && !odd_col) begin
      hold     <= bus.pix_in;
      top_hold <= buf_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win_a      <= '0;
      win_b      <= '0;
      win_c      <= '0;
      win_d      <= '0;
      win_en     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      win_en     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (bus.pix_valid) begin
        col      <= col_nxt;
        row      <= row_nxt;
        sync_err <= sof_take && !at_origin;
        if (odd_row && odd_col) begin
          win_a      <= top_hold;
          win_b      <= buf_rd;
          win_c      <= hold;
          win_d      <= bus.pix_in;
          win_en     <= 1'b1;
          frame_done <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
        end
      end
    end
  end

  assign bus.win_a      = win_a;
  assign bus.win_b      = win_b;
  assign bus.win_c      = win_c;
  assign bus.win_d      = win_d;
  assign bus.win_en     = win_en;
  assign bus.frame_done = frame_done;
  assign bus.sync_err   = sync_err;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: hand-computed window table plus frame
// sequences for gaps, reset, back-to-back frames and resync.
module tb_pool_window_gen;
  import pool_pkg::*;

  localparam int W    = POOL_IMG_W;
  localparam int H    = POOL_IMG_H;
  localparam int NPIX = W * H;
  localparam int NWIN = (W / 2) * (H / 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_window_gen_if #(.DATA_W(POOL_DATA_W)) bus ();

  pool_window_gen #(
    .DATA_W (POOL_DATA_W),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         scen;
    int         idx;
    logic [7:0] a, b, c, d;
    logic       done;
  } vec_t;
  vec_t vecs[10];

  logic [32:0] cap_q[$];
  logic [32:0] exp_q[$];
  int first_en_cyc, err_cnt, err_cyc, done_cnt, consec, stray_done;
  int p10_cyc, sof_cyc;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cap_q.delete();
    first_en_cyc = -1;
    err_cnt      = 0;
    err_cyc      = -1;
    done_cnt     = 0;
    consec       = 0;
    stray_done   = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.win_en) begin
        cap_q.push_back({bus.frame_done, bus.win_a, bus.win_b, bus.win_c, bus.win_d});
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (prev_en) consec++;
      end
      if (bus.frame_done) begin
        done_cnt++;
        if (!bus.win_en) stray_done++;
      end
      if (bus.sync_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_en = bus.win_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] pix_val(input int kind, input int k);
    logic [7:0] v;
    v = 8'(k + 1);
    if (kind == 1) begin
      case (k)
        0: v = 8'h80;
        1: v = 8'h7F;
        2: v = 8'hFF;
        3: v = 8'h00;
        8: v = 8'h05;
        9: v = 8'hFA;
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_in    = 8'($urandom);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic s);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = s;
    bus.pix_in    = p;
    if (s) sof_cyc = cyc;
  endtask

  task automatic send_pixels(input int kind, input int n, input logic sof_first, input int idle_pct);
    for (int k = 0; k < n; k++) begin
      int g = 0;
      while (g < 5 && $urandom_range(99) < idle_pct) begin
        idle(1);
        g++;
      end
      drive(pix_val(kind, k), sof_first && (k == 0));
      if (k == 9) p10_cyc = cyc;
    end
  endtask

  // Independent model of the 1..64 frame: window k covers rows 2r,2r+1, cols 2c,2c+1.
  task automatic compare_model(input string name, input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < NWIN; k++) begin
        int r, c, base;
        r    = k / (W / 2);
        c    = k % (W / 2);
        base = 2 * r * W + 2 * c;
        exp_q.push_back({(k == NWIN - 1), 8'(base + 1), 8'(base + 2), 8'(base + W + 1), 8'(base + W + 2)});
      end
    end
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s_win%0d", name, i), cap_q[i], exp_q[i]);
    end
  endtask

  task automatic run_table(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        if (vecs[i].idx < cap_q.size()) begin
          check($sformatf("tbl_s%0d_win%0d", scen, vecs[i].idx), cap_q[vecs[i].idx],
                {vecs[i].done, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d});
        end else begin
          check($sformatf("tbl_s%0d_win%0d_present", scen, vecs[i].idx), cap_q.size(), vecs[i].idx + 1);
        end
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{0, 0,  8'h01, 8'h02, 8'h09, 8'h0A, 1'b0};
    vecs[1] = '{0, 1,  8'h03, 8'h04, 8'h0B, 8'h0C, 1'b0};
    vecs[2] = '{0, 4,  8'h11, 8'h12, 8'h19, 8'h1A, 1'b0};
    vecs[3] = '{0, 15, 8'h37, 8'h38, 8'h3F, 8'h40, 1'b1};
    vecs[4] = '{1, 0,  8'h80, 8'h7F, 8'h05, 8'hFA, 1'b0};
    vecs[5] = '{1, 1,  8'hFF, 8'h00, 8'h0B, 8'h0C, 1'b0};
    vecs[6] = '{2, 0,  8'h01, 8'h02, 8'h09, 8'h0A, 1'b0};
    vecs[7] = '{3, 0,  8'h01, 8'h02, 8'h09, 8'h0A, 1'b0};
    vecs[8] = '{3, 15, 8'h37, 8'h38, 8'h3F, 8'h40, 1'b1};
    vecs[9] = '{0, 2,  8'h05, 8'h06, 8'h0D, 8'h0E, 1'b0};

    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_in    = '0;
    p10_cyc       = -1;
    sof_cyc       = -1;
    clear_mon();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_win_en", bus.win_en, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_sync_err", bus.sync_err, 0);
    check("rst_win_abcd", {bus.win_a, bus.win_b, bus.win_c, bus.win_d}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // continuous 1..64 frame
    clear_mon();
    send_pixels(0, NPIX, 1'b0, 0);
    idle(4);
    compare_model("cont", 1);
    run_table(0);
    check("cont_latency", first_en_cyc, p10_cyc + 1);
    check("cont_done_cnt", done_cnt, 1);
    check("cont_sync_err", err_cnt, 0);

    // signed pass-through
    clear_mon();
    send_pixels(1, NPIX, 1'b0, 0);
    idle(4);
    check("signed_count", cap_q.size(), NWIN);
    run_table(1);

    // random idle gaps
    clear_mon();
    send_pixels(0, NPIX, 1'b0, 30);
    idle(4);
    compare_model("gaps", 1);
    check("gaps_consecutive_en", consec, 0);
    check("gaps_done_cnt", done_cnt, 1);

    // mid-frame reset after 20 pixels
    send_pixels(0, 20, 1'b0, 0);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_win_en", bus.win_en, 0);
    check("midrst_win_abcd", {bus.win_a, bus.win_b, bus.win_c, bus.win_d}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    send_pixels(0, NPIX, 1'b0, 0);
    idle(4);
    compare_model("midrst", 1);
    run_table(2);

    // back-to-back frames with sof
    clear_mon();
    send_pixels(0, NPIX, 1'b1, 0);
    send_pixels(0, NPIX, 1'b1, 0);
    idle(4);
    compare_model("b2b", 2);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_sync_err", err_cnt, 0);
    check("b2b_stray_done", stray_done, 0);

    // sof on pixel 37 resyncs
    send_pixels(0, 36, 1'b0, 0);
    clear_mon();
    send_pixels(0, NPIX, 1'b1, 0);
    idle(4);
    check("resync_err_cnt", err_cnt, 1);
    check("resync_err_cyc", err_cyc, sof_cyc + 1);
    compare_model("resync", 1);
    run_table(3);
    check("resync_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
